// File: rtl/char_lcd_sequencer_if.sv
// ---------------------------------------------------------------------------
// char_lcd_sequencer_if
// Byte request channel into the character LCD sequencer.
//   req_valid  requester -> sequencer  byte present
//   req_ready  sequencer -> requester  byte can be accepted this cycle
//   req_rs     requester -> sequencer  0 = command, 1 = data
//   req_data   requester -> sequencer  byte to write
// master: the requester (Nios-side register logic); slave: the sequencer.
// ---------------------------------------------------------------------------
interface char_lcd_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic [7:0] req_data;

    modport master (
        output req_valid,
        output req_rs,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_rs,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/char_lcd_sequencer.sv
// ---------------------------------------------------------------------------
// char_lcd_sequencer
// Bus-timing sequencer for an HD44780-compatible 16x2 character LCD. After
// reset it waits for the panel to power up, writes the fixed init sequence,
// then accepts one command/data byte at a time and produces the RS/RW/DATA
// setup, the EN strobe, the hold and the execution wait for each.
//
// Ports:
//   clk_clk        clock, rising edge
//   reset_reset_n  synchronous active-low reset
//   req            byte request channel (slave side)
//   blon_en        backlight request, registered onto lcd_BLON
//   init_done      init sequence finished (sticky until reset)
//   lcd_data_out   value driven onto the LCD DATA bus
//   lcd_data_oe    1 = drive DATA (the top level builds the inout)
//   lcd_data_in    DATA pad readback (busy-flag polling only)
//   lcd_ON, lcd_BLON, lcd_EN, lcd_RS, lcd_RW  LCD control pins
//
// Build option: define LCD_BUSY_POLL_EN to replace the fixed execution wait
// (from the 4th init byte on, and for every user byte) with busy-flag reads.
// ---------------------------------------------------------------------------
module char_lcd_sequencer #(
    parameter int SETUP_CYC      = 4,
    parameter int EN_HIGH_CYC    = 25,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 82000,
    parameter int INIT_WAIT_CYC  = 750000
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    char_lcd_sequencer_if.slave   req,
    input  logic                  blon_en,
    output logic                  init_done,
    output logic [7:0]            lcd_data_out,
    output logic                  lcd_data_oe,
    input  logic [7:0]            lcd_data_in,
    output logic                  lcd_ON,
    output logic                  lcd_BLON,
    output logic                  lcd_EN,
    output logic                  lcd_RS,
    output logic                  lcd_RW
);

    // Counters load N-1 and count down to zero, so N cycles per phase.
    localparam logic [19:0] SETUP_LD = 20'(SETUP_CYC - 1);
    localparam logic [19:0] EN_LD    = 20'(EN_HIGH_CYC - 1);
    localparam logic [19:0] CMD_LD   = 20'(CMD_WAIT_CYC - 1);
    localparam logic [19:0] CLEAR_LD = 20'(CLEAR_WAIT_CYC - 1);
    localparam logic [19:0] INIT_LD  = 20'(INIT_WAIT_CYC - 1);

    typedef enum logic [3:0] {
        PWR_WAIT,
        INIT_LOAD,
        SETUP,
        EN_HI,
        HOLD,
        WAIT,
        IDLE
`ifdef LCD_BUSY_POLL_EN
        ,
        POLL_SETUP,
        POLL_EN,
        POLL_HOLD
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        rs_q, rs_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        on_q;
    logic        blon_q;

    // Where a finished byte goes next: the next init byte, or IDLE.
    state_t      fin_state;
    logic [2:0]  fin_idx;
    logic        fin_done;
    logic        long_wait;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_byte = 8'h38;  // 8-bit bus, 2 lines, 5x8
            3'd3:             init_byte = 8'h0C;  // display on, cursor off
            3'd4:             init_byte = 8'h01;  // clear
            default:          init_byte = 8'h06;  // entry mode: increment
        endcase
    endfunction

`ifdef LCD_BUSY_POLL_EN
    logic bf_q, bf_d;
    logic polling;
    assign polling = (state_q == POLL_SETUP) || (state_q == POLL_EN) ||
                     (state_q == POLL_HOLD);
`else
    logic unused_data_in;
    assign unused_data_in = ^lcd_data_in;
`endif

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q <= PWR_WAIT;
            cnt_q   <= INIT_LD;
            idx_q   <= 3'd0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            on_q    <= 1'b0;
            blon_q  <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
            bf_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            done_q  <= done_d;
            on_q    <= 1'b1;
            blon_q  <= blon_en;
`ifdef LCD_BUSY_POLL_EN
            bf_q    <= bf_d;
`endif
        end
    end

    always_comb begin
        fin_state = IDLE;
        fin_idx   = idx_q;
        fin_done  = 1'b1;
        if (!done_q && idx_q != 3'd5) begin
            fin_state = INIT_LOAD;
            fin_idx   = idx_q + 3'd1;
            fin_done  = 1'b0;
        end
        // Clear and home need the long execution time.
        long_wait = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

        state_d = state_q;
        cnt_d   = cnt_q - 20'd1;
        idx_d   = idx_q;
        rs_d    = rs_q;
        data_d  = data_q;
        done_d  = done_q;
`ifdef LCD_BUSY_POLL_EN
        bf_d    = bf_q;
`endif
        case (state_q)
            PWR_WAIT: if (cnt_q == 20'd0) state_d = INIT_LOAD;
            INIT_LOAD: begin
                rs_d    = 1'b0;
                data_d  = init_byte(idx_q);
                state_d = SETUP;
                cnt_d   = SETUP_LD;
            end
            SETUP: if (cnt_q == 20'd0) begin
                state_d = EN_HI;
                cnt_d   = EN_LD;
            end
            EN_HI: if (cnt_q == 20'd0) begin
                state_d = HOLD;
                cnt_d   = SETUP_LD;
            end
            HOLD: if (cnt_q == 20'd0) begin
                state_d = WAIT;
                cnt_d   = long_wait ? CLEAR_LD : CMD_LD;
`ifdef LCD_BUSY_POLL_EN
                // The first three 0x38 writes precede a valid busy flag.
                if (done_q || idx_q >= 3'd3) begin
                    state_d = POLL_SETUP;
                    cnt_d   = SETUP_LD;
                end
`endif
            end
            WAIT: if (cnt_q == 20'd0) begin
                state_d = fin_state;
                idx_d   = fin_idx;
                done_d  = fin_done;
            end
            IDLE: if (req.req_valid) begin
                rs_d    = req.req_rs;
                data_d  = req.req_data;
                state_d = SETUP;
                cnt_d   = SETUP_LD;
            end
`ifdef LCD_BUSY_POLL_EN
            POLL_SETUP: if (cnt_q == 20'd0) begin
                state_d = POLL_EN;
                cnt_d   = EN_LD;
            end
            POLL_EN: if (cnt_q == 20'd0) begin
                bf_d    = lcd_data_in[7];
                state_d = POLL_HOLD;
                cnt_d   = SETUP_LD;
            end
            POLL_HOLD: if (cnt_q == 20'd0) begin
                if (bf_q) begin
                    state_d = POLL_SETUP;
                    cnt_d   = SETUP_LD;
                end else begin
                    state_d = fin_state;
                    idx_d   = fin_idx;
                    done_d  = fin_done;
                end
            end
`endif
            default: state_d = PWR_WAIT;
        endcase
    end

    assign req.req_ready = (state_q == IDLE);
    assign init_done     = done_q;
    assign lcd_data_out  = data_q;
    assign lcd_ON        = on_q;
    assign lcd_BLON      = blon_q;
`ifdef LCD_BUSY_POLL_EN
    assign lcd_EN        = (state_q == EN_HI) || (state_q == POLL_EN);
    assign lcd_RS        = polling ? 1'b0 : rs_q;
    assign lcd_RW        = polling;
    assign lcd_data_oe   = !polling;
`else
    assign lcd_EN        = (state_q == EN_HI);
    assign lcd_RS        = rs_q;
    assign lcd_RW        = 1'b0;
    assign lcd_data_oe   = 1'b1;
`endif

endmodule
